// File: rtl/apb_master.sv
// APB requester, one transfer in flight: IDLE -> SETUP -> ACCESS, response pulse 3+ cycles after accept, no rsp backpressure.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS to TIMEOUT_CYCLES cycles (error response on expiry).
module apb_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int SEL_BIT        = 63,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  slverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || SEL_BIT >= ADDR_WIDTH) begin : g_bad_param
    $error("apb_master: TIMEOUT_CYCLES must be 1..255 and SEL_BIT < ADDR_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    psel1_q, psel1_d;
  logic                    psel2_q, psel2_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0]              tmo_cnt_q, tmo_cnt_d;
  logic                    tmo_hit;
`endif

  always_comb begin
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_hit     = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel1_d  = ~cmd_addr[SEL_BIT];
          psel2_d  = cmd_addr[SEL_BIT];
          state_d  = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the last counted cycle beats the timeout.
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = slverr;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
        if (rsp_valid_d) begin
          state_d   = IDLE;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; expected responses queue up at command issue and are checked when rsp_valid fires.
`timescale 1ns/1ps
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [63:0] PADDR, PWDATA;
  logic [63:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        slverr = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .SEL_BIT(63), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .slverr(slverr)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_rsp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] junk64();
    return {$urandom, $urandom};
  endfunction

  // Advance to the next falling edge and score any response the DUT produced.
  task automatic tick();
    rsp_t e;
    @(negedge PCLK);
    if (rsp_valid === 1'b1) begin
      chk("rsp_one_cycle", {63'd0, prev_rsp}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
    prev_rsp = rsp_valid;
  endtask

  task automatic chk_bus(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic pen);
    chk({tag, "_psel1"}, {63'd0, PSEL1}, {63'd0, ~a[63]});
    chk({tag, "_psel2"}, {63'd0, PSEL2}, {63'd0, a[63]});
    chk({tag, "_penable"}, {63'd0, PENABLE}, {63'd0, pen});
    chk({tag, "_paddr"}, PADDR, a);
    chk({tag, "_pwrite"}, {63'd0, PWRITE}, {63'd0, w});
    chk({tag, "_pwdata"}, PWDATA, d);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  // Full transfer: returns at the falling edge of the rsp_valid cycle.
  task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d, input int nwait,
                      input logic [63:0] rd, input logic se, input logic hold_valid);
    rsp_t e;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("accept_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    e.rdata = w ? 64'd0 : rd;
    e.err   = se;
    exp_q.push_back(e);
    tick();
    cmd_valid = hold_valid; cmd_write = ~w; cmd_addr = junk64(); cmd_wdata = junk64();
    chk_bus("setup", w, a, d, 1'b0);
    PREADY = 1'b1; PRDATA = junk64(); slverr = 1'b1;
    tick();
    for (int i = 0; i <= nwait; i++) begin
      PREADY = (i == nwait);
      PRDATA = (i == nwait) ? rd : junk64();
      slverr = (i == nwait) ? se : 1'($urandom);
      chk_bus("access", w, a, d, 1'b1);
      tick();
    end
    PREADY = 1'b0; slverr = 1'b0; PRDATA = junk64();
    chk("done_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("done_psel", {62'd0, PSEL1, PSEL2}, 64'd0);
    chk("done_penable", {63'd0, PENABLE}, 64'd0);
    chk("done_cmd_ready", {63'd0, cmd_ready}, 64'd1);
  endtask

  // Issue a read and stop at the first ACCESS cycle with PREADY low.
  task automatic start_read(input logic [63:0] a);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = junk64();
    chk("start_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    tick();
    chk("start_penable", {63'd0, PENABLE}, 64'd1);
  endtask

  initial begin
    int n;

    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_apb_ctl", {60'd0, PSEL1, PSEL2, PENABLE, PWRITE}, 64'd0);
    chk("rst_rsp_ctl", {62'd0, rsp_valid, rsp_err}, 64'd0);
    chk("rst_paddr", PADDR, 64'd0);
    chk("rst_pwdata", PWDATA, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    tick(); tick();
    PRESETn = 1'b1;
    tick();

    // Zero-wait write to slave 1; PRDATA garbage must not leak into the write response.
    xfer(1'b1, 64'h10, 64'hDEAD_BEEF, 0, 64'hFFFF_0000_FFFF, 1'b0, 1'b0);
    tick();
    chk("w_rsp_valid_low", {63'd0, rsp_valid}, 64'd0);
    chk("w_rdata_zero", rsp_rdata, 64'd0);

    // Read from slave 2 with 3 wait states; response must hold afterwards.
    xfer(1'b0, 64'h8000_0000_0000_0020, 64'h0, 3, 64'h1234, 1'b0, 1'b0);
    tick(); tick();
    chk("r_rdata_hold", rsp_rdata, 64'h1234);
    chk("r_err_hold", {63'd0, rsp_err}, 64'd0);

    // Slave error on a read.
    xfer(1'b0, 64'h40, 64'h0, 1, 64'hABCD, 1'b1, 1'b0);
    tick();
    chk("err_pulse_low", {63'd0, rsp_valid}, 64'd0);
    chk("err_hold", {63'd0, rsp_err}, 64'd1);

    // Back-to-back with cmd_valid held: the second is taken in the rsp_valid cycle.
    xfer(1'b1, 64'h8000_0000_0000_0008, 64'h5555_AAAA, 0, 64'h0, 1'b0, 1'b1);
    xfer(1'b0, 64'h18, 64'h0, 2, 64'h77, 1'b0, 1'b1);
    xfer(1'b1, 64'h28, 64'h0123_4567_89AB_CDEF, 0, 64'h9, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    tick();

    // PREADY on the 16th ACCESS cycle completes normally.
    xfer(1'b0, 64'h30, 64'h0, 15, 64'hC0FFEE, 1'b0, 1'b0);
    tick();

    start_read(64'h8000_0000_0000_0100);
    PRDATA = 64'hBAD0_BAD0;
`ifdef APB_MASTER_TIMEOUT_EN
    begin
      rsp_t e;
      e.rdata = 64'd0;
      e.err   = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      chk("tmo_penable", {63'd0, PENABLE}, 64'd1);
      tick();
    end
    chk("tmo_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("tmo_idle", {63'd0, cmd_ready}, 64'd1);
    tick();
    start_read(64'h8000_0000_0000_0200);
    tick(); tick();
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (PENABLE === 1'b1 && rsp_valid === 1'b0) n++;
      tick();
    end
    chk("wait_penable_100", 64'(n), 64'd100);
`endif

    // Reset mid-ACCESS: bus drops immediately, transfer is abandoned.
    chk("pre_rst_psel2", {63'd0, PSEL2}, 64'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", {62'd0, PSEL1, PSEL2}, 64'd0);
    chk("rst_mid_penable", {63'd0, PENABLE}, 64'd0);
    chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    PRESETn = 1'b1;
    #1;
    chk("rst_rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

    xfer(1'b0, 64'h8000_0000_0000_0040, 64'h0, 0, 64'h4242, 1'b0, 1'b0);
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64, meaning address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, meaning data width.
REQ-003 The block SHALL have parameter SEL_BIT, default 63, meaning the address bit that selects the slave.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles (range 1..255).
REQ-005 The block SHALL have port PCLK, input, 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-006 The block SHALL have port PRESETn, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-009 The block SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port cmd_addr, input, ADDR_WIDTH bits: transfer address.
REQ-011 The block SHALL have port cmd_wdata, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: error flag for the completed transfer.
REQ-015 The block SHALL have APB outputs PSEL1 and PSEL2 (1 bit each), PENABLE (1), PWRITE (1), PADDR (ADDR_WIDTH) and PWDATA (DATA_WIDTH).
REQ-016 The block SHALL have APB inputs PRDATA (DATA_WIDTH), PREADY (1) and slverr (1).

Function
REQ-017 The FSM SHALL have states IDLE, SETUP and ACCESS; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted when cmd_valid and cmd_ready are both 1 in IDLE; cmd_addr, cmd_wdata and cmd_write SHALL be registered onto PADDR, PWDATA and PWRITE, and the next state SHALL be SETUP.
REQ-019 In SETUP, exactly one of PSEL1 and PSEL2 SHALL be 1: PSEL1 when PADDR[SEL_BIT]=0, PSEL2 when PADDR[SEL_BIT]=1. PENABLE SHALL be 0. The next state SHALL be ACCESS unconditionally.
REQ-020 In ACCESS, PENABLE SHALL be 1, and PSEL, PADDR, PWRITE and PWDATA SHALL be held stable.
REQ-021 ACCESS SHALL remain while PREADY=0.
REQ-022 When PREADY=1 in ACCESS:
- PRDATA (reads only; writes give 0) SHALL be registered to rsp_rdata.
- slverr SHALL be registered to rsp_err.
- rsp_valid SHALL pulse 1 for one cycle, in the cycle following the PREADY cycle.
- The FSM SHALL return to IDLE.
REQ-023 In IDLE, PSEL1, PSEL2 and PENABLE SHALL be 0.
REQ-024 A command presented while rsp_valid is high SHALL be accepted in that same cycle (back-to-back); minimum transfer spacing SHALL be 3 cycles.
REQ-025 The response interface SHALL have no backpressure.
REQ-026 rsp_rdata and rsp_err SHALL hold their values until the next completion.
REQ-027 PREADY, PRDATA and slverr SHALL be ignored outside ACCESS.

Reset
REQ-028 PRESETn=0 SHALL immediately force:
- state to IDLE;
- cmd_ready to 1 after release;
- PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid and rsp_err to 0;
- PADDR, PWDATA and rsp_rdata to 0;
- the timeout counter to 0.
REQ-029 Reset asserted in SETUP or ACCESS SHALL abort the transfer with no rsp_valid.

Configuration
REQ-030 The macro APB_MASTER_TIMEOUT_EN, when defined, SHALL enable an 8-bit ACCESS-cycle counter that is cleared on entry to SETUP.
REQ-031 With APB_MASTER_TIMEOUT_EN defined, when TIMEOUT_CYCLES ACCESS cycles elapse with PREADY=0:
- the transfer SHALL terminate to IDLE;
- rsp_valid=1, rsp_err=1 and rsp_rdata=0 SHALL be returned.
- PREADY=1 on the final counted cycle SHALL win over the timeout.
REQ-032 Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-033 Write, addr 0x10, data 0xDEADBEEF, PREADY=1 in the first ACCESS cycle -> PSEL1=1 for 2 cycles, PENABLE=1 for 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-034 Read, addr 0x8000_0000_0000_0020, slave returns 0x1234 with PREADY after 3 wait cycles -> PSEL2=1, PSEL1=0, rsp_rdata=0x1234, signals stable throughout ACCESS.
REQ-035 Read with slverr=1 at the PREADY cycle -> rsp_err=1 and rsp_valid pulse of one cycle.
REQ-036 Two commands back-to-back with cmd_valid held high -> second accepted in the rsp_valid cycle, no idle gap beyond 3-cycle spacing.
REQ-037 APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, PREADY held 0 -> rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; not defined -> PENABLE stays 1 for 100 cycles.
REQ-038 PRESETn driven low mid-ACCESS -> PSEL and PENABLE drop asynchronously, no rsp_valid, cmd_ready=1 after release.
